uart_frame_decoder: RTL and testbench
=====================================

Name: uart_frame_decoder

Overview:
- Downstream consumer of the UART core's RX FIFO.
- Pulls received bytes through the FIFO read port and recognises framed packets: SOF, LEN, payload, CHK.
- Buffers the payload internally and releases it on a valid/ready byte stream only when the checksum matches.
- Reports checksum, length and inter-byte timeout errors as one-cycle pulses.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame marker
MAX_LEN, 16, maximum payload length in bytes (1..255)
TIMEOUT_CYC, 50000, idle clk cycles allowed between bytes inside a frame before abort

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_empty  input  1  RX FIFO empty flag from UART core
rx_data  input  8  RX FIFO head byte; first-word-fall-through, valid whenever rx_empty=0
rx_rd_en  output  1  pop RX FIFO head this cycle
m_data  output  8  payload byte out
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts byte
m_last  output  1  m_data is the final payload byte of the frame
frame_ok  output  1  one-cycle pulse: frame checksum good, payload release starts
frame_err  output  1  one-cycle pulse: frame aborted
err_code  output  2  cause, valid with frame_err: 01 checksum, 10 length, 11 timeout; holds last value otherwise

Behaviour:
- Reset (async, rst_n=0): state HUNT; rx_rd_en=0 (explicitly gated by rst_n); m_valid=0, m_last=0, m_data=0, frame_ok=0, frame_err=0, err_code=00; counters cleared; buffer contents don't-care.
- Byte consumption: rx_rd_en = !rx_empty && state in {HUNT, LEN, PAYLOAD, CHK}, combinational. At most one byte per cycle. A byte is consumed on the posedge where rx_rd_en=1, using rx_data of that cycle.
- In OUT state rx_rd_en=0, so the FIFO backs up and the UART core keeps buffering.
- HUNT: a byte equal to SOF_BYTE goes to LEN; any other byte is discarded silently.
- LEN: if the byte is 0 or >MAX_LEN, pulse frame_err with err_code=10 and return to HUNT. Otherwise store len, clear idx, set chk=byte, go to PAYLOAD.
- PAYLOAD: write the byte to buf[idx], update chk ^= byte, idx++. When idx reaches len-1 at the write, go to CHK.
- CHK: if the byte equals chk, pulse frame_ok, set m_valid=1 with m_data=buf[0] and m_last=(len==1) on the next cycle, then go to OUT. Otherwise pulse frame_err with err_code=01 and return to HUNT.
- Checksum: 8-bit XOR of LEN and all payload bytes. SOF is excluded.
- Latency: m_valid rises on the cycle after the CHK byte is consumed. frame_ok and m_valid first assert on the same cycle.
- OUT: m_data=buf[oidx]. On m_valid && m_ready, oidx++ and the next byte is presented on the next cycle, allowing back-to-back transfers at 1 byte/cycle.
- m_data, m_last are stable while m_valid=1 && m_ready=0.
- After the handshake on m_last, the next cycle has m_valid=0, m_last=0 and state HUNT. HUNT may consume a byte in that same cycle.
- Timeout: in LEN, PAYLOAD or CHK, count cycles with no byte consumed; the counter is cleared on every consumed byte and on entering LEN. When the count reaches TIMEOUT_CYC, pulse frame_err with err_code=11 and return to HUNT; partial payload is discarded. No timeout applies in HUNT or OUT.
- No timeout in OUT: m_ready may stall indefinitely.
- A mid-frame SOF_BYTE value is treated as data, with no resync.
- frame_ok and frame_err are mutually exclusive and never asserted simultaneously.
- Reset asserted mid-frame or mid-OUT aborts immediately to the reset values above, with no error pulse. Bytes already popped are lost; bytes still in the FIFO are handled by the UART core's reset.
- Widths: len, idx and oidx use $clog2(MAX_LEN+1) bits. The timeout counter uses $clog2(TIMEOUT_CYC+1) bits and saturates.

Test Plan:
- Good frame: push A5 03 11 22 33 03 (XOR 03^11^22^33=03), m_ready=1 -> frame_ok pulse once; m_data 11,22,33 on three consecutive cycles starting 1 cycle after 03 popped; m_last only on 33; no frame_err.
- Backpressure: same frame, m_ready low 5 cycles then toggled -> m_data/m_last held while stalled; exactly 3 handshakes; rx_rd_en=0 throughout OUT even with later bytes A5 01 77 76 queued; second frame delivered afterward (frame_ok, m_data=77 with m_last).
- Bad checksum: A5 02 AA BB 00 -> frame_err with err_code=01, no m_valid; a following good frame A5 01 5A 5B decodes normally.
- Length errors: A5 00 -> err_code=10; A5 11 with MAX_LEN=16 -> err_code=10; in both cases no payload is consumed, and subsequent garbage bytes 00 FF are dropped silently in HUNT.
- Timeout: TIMEOUT_CYC=100; push A5 04 01 02, then hold rx_empty=1 -> frame_err with err_code=11 exactly 100 cycles after byte 02 popped; a later good frame passes.
- Reset mid-frame: assert rst_n=0 during PAYLOAD and again during OUT -> all outputs 0 asynchronously, no pulse; after release, the A5 01 42 43 frame decodes to m_data=42 with m_last.

Source files
------------

// File: rtl/uart_frame_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_frame_decoder_if
// Purpose : RX FIFO read port, payload stream and status pulses of the decoder.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_frame_decoder_if;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rx_rd_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    input  rx_empty,
    input  rx_data,
    output rx_rd_en,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last,
    output frame_ok,
    output frame_err,
    output err_code
  );

  modport slave (
    output rx_empty,
    output rx_data,
    input  rx_rd_en,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last,
    input  frame_ok,
    input  frame_err,
    input  err_code
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module  : uart_frame_decoder
// Purpose : Pulls SOF/LEN/payload/CHK frames from a UART RX FIFO and releases
//           checksum-verified payloads on a valid/ready byte stream.
// Revision: 1.0 - initial release
// ============================================================================
module uart_frame_decoder #(
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_frame_decoder_if.master  bus
);

  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TW-1:0] C_TO_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [8:0]    C_MAX_LEN = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] oidx_q, oidx_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    pay_mem_q [DEPTH];

  logic          rd_en;
  logic          in_frame;
  logic          timeout_hit;
  logic          pay_we;
  logic          out_last;
  logic [LW-1:0] len_last;

  // Gated by rst_n so no byte is popped while the core sits in reset.
  assign rd_en       = rst_n && !bus.rx_empty && (state_q != S_OUT);
  assign in_frame    = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign timeout_hit = in_frame && !rd_en && (tmo_q == C_TO_LAST);
  assign len_last    = len_q - LW'(1);
  assign out_last    = (oidx_q == len_last);

  assign bus.rx_rd_en  = rd_en;
  assign bus.m_valid   = (state_q == S_OUT);
  assign bus.m_last    = (state_q == S_OUT) && out_last;
  assign bus.m_data    = (state_q == S_OUT) ? pay_mem_q[oidx_q[AW-1:0]] : 8'h00;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    oidx_d      = oidx_q;
    chk_d       = chk_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    pay_we      = 1'b0;

    tmo_d = '0;
    if (in_frame && !rd_en) begin
      tmo_d = (tmo_q == C_TO_MAX) ? tmo_q : tmo_q + TW'(1);
    end

    case (state_q)
      S_HUNT: begin
        if (rd_en && (bus.rx_data == SOF_BYTE)) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rd_en) begin
          if ((bus.rx_data == 8'h00) || ({1'b0, bus.rx_data} > C_MAX_LEN)) begin
            state_d     = S_HUNT;
            frame_err_d = 1'b1;
            err_code_d  = 2'b10;
          end else begin
            len_d   = bus.rx_data[LW-1:0];
            idx_d   = '0;
            chk_d   = bus.rx_data;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rd_en) begin
          pay_we = 1'b1;
          chk_d  = chk_q ^ bus.rx_data;
          idx_d  = idx_q + LW'(1);
          if (idx_q == len_last) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (rd_en) begin
          if (bus.rx_data == chk_q) begin
            frame_ok_d = 1'b1;
            oidx_d     = '0;
            state_d    = S_OUT;
          end else begin
            state_d     = S_HUNT;
            frame_err_d = 1'b1;
            err_code_d  = 2'b01;
          end
        end
      end
      S_OUT: begin
        if (bus.m_ready) begin
          if (out_last) begin
            state_d = S_HUNT;
          end else begin
            oidx_d = oidx_q + LW'(1);
          end
        end
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase

    // timeout_hit implies no byte this cycle, so it never collides with the above.
    if (timeout_hit) begin
      state_d     = S_HUNT;
      frame_err_d = 1'b1;
      err_code_d  = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HUNT;
      len_q       <= '0;
      idx_q       <= '0;
      oidx_q      <= '0;
      chk_q       <= 8'h00;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      oidx_q      <= oidx_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload storage needs no reset; it is only read after being fully written.
  always_ff @(posedge clk) begin
    if (pay_we) begin
      pay_mem_q[idx_q[AW-1:0]] <= bus.rx_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_frame_decoder
// Purpose : Directed frame vectors plus backpressure, timeout and reset cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_frame_decoder;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  uart_frame_decoder_if bus();

  uart_frame_decoder #(
    .SOF_BYTE   (8'hA5),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           nb;
    logic [159:0] b;
    int           np;
    logic [159:0] p;
    int           exp_ok;
    int           exp_err;
    logic [1:0]   code;
  } vec_t;

  vec_t vecs[9];

  logic [7:0] fifo[$];
  bit         will_pop = 1'b0;
  int         cyc = 0;
  int         pop_cyc = 0;

  int         n_ok = 0, n_err = 0, ok_cyc = 0, err_cyc = 0;
  int         n_both = 0, n_rd_out = 0, n_unstable = 0;
  logic [1:0] err_seen = 2'b00;
  logic [7:0] hs_data[$];
  bit         hs_last[$];
  int         hs_cyc[$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO model: first-word-fall-through head, popped on the edge the DUT reads it.
  initial begin
    bus.rx_empty = 1'b1;
    bus.rx_data  = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      if (will_pop && fifo.size() > 0) begin
        void'(fifo.pop_front());
        pop_cyc = cyc;
      end
      #1;
      bus.rx_empty = (fifo.size() == 0);
      bus.rx_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  always @(negedge clk) begin
    will_pop = bus.rx_rd_en;
    if (bus.frame_ok) begin
      n_ok++;
      ok_cyc = cyc;
    end
    if (bus.frame_err) begin
      n_err++;
      err_cyc  = cyc;
      err_seen = bus.err_code;
    end
    if (bus.frame_ok && bus.frame_err) n_both++;
    if (bus.m_valid && bus.rx_rd_en) n_rd_out++;
    if (rst_n && prev_stall &&
        (!bus.m_valid || bus.m_data != prev_data || bus.m_last != prev_last)) n_unstable++;
    prev_stall = rst_n && bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
    prev_last  = bus.m_last;
    if (bus.m_valid && bus.m_ready) begin
      hs_data.push_back(bus.m_data);
      hs_last.push_back(bus.m_last);
      hs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [159:0] v, input int n, input int k);
    return v[8*(n-1-k) +: 8];
  endfunction

  task automatic push_vec_bytes(input int v);
    for (int k = 0; k < vecs[v].nb; k++) fifo.push_back(byte_at(vecs[v].b, vecs[v].nb, k));
  endtask

  task automatic wait_ok(input int base, input string name);
    int t = 0;
    while (n_ok == base && t < 200) begin
      step(1);
      t++;
    end
    chk({name, " frame_ok seen"}, n_ok - base, 1);
  endtask

  task automatic run_vec(input int v);
    int ok0 = n_ok;
    int err0 = n_err;
    int hs0 = hs_data.size();
    int t = 0;
    int got;
    bus.m_ready = 1'b1;
    push_vec_bytes(v);
    while (fifo.size() != 0 && t < 100) begin
      step(1);
      t++;
    end
    chk($sformatf("v%0d fifo drained", v), fifo.size(), 0);
    step(30);
    got = hs_data.size() - hs0;
    chk($sformatf("v%0d frame_ok count", v), n_ok - ok0, vecs[v].exp_ok);
    chk($sformatf("v%0d frame_err count", v), n_err - err0, vecs[v].exp_err);
    if (vecs[v].exp_err > 0) chk($sformatf("v%0d err_code", v), err_seen, vecs[v].code);
    chk($sformatf("v%0d handshakes", v), got, vecs[v].np);
    for (int k = 0; k < vecs[v].np && k < got; k++) begin
      chk($sformatf("v%0d m_data[%0d]", v, k), hs_data[hs0+k], byte_at(vecs[v].p, vecs[v].np, k));
      chk($sformatf("v%0d m_last[%0d]", v, k), hs_last[hs0+k], (k == vecs[v].np - 1) ? 1 : 0);
    end
    if (vecs[v].exp_ok > 0 && got == vecs[v].np && got > 0) begin
      chk($sformatf("v%0d frame_ok cycle after CHK pop", v), ok_cyc, pop_cyc);
      chk($sformatf("v%0d first m_valid with frame_ok", v), hs_cyc[hs0], ok_cyc);
      chk($sformatf("v%0d back-to-back output", v), hs_cyc[hs0+got-1] - hs_cyc[hs0], got - 1);
    end
  endtask

  task automatic set_vec(input int i, input int nb, input logic [159:0] b, input int np,
                         input logic [159:0] p, input int ok, input int err, input logic [1:0] code);
    vecs[i].nb = nb; vecs[i].b = b; vecs[i].np = np; vecs[i].p = p;
    vecs[i].exp_ok = ok; vecs[i].exp_err = err; vecs[i].code = code;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " rx_rd_en"},  bus.rx_rd_en, 0);
    chk({tag, " m_valid"},   bus.m_valid, 0);
    chk({tag, " m_last"},    bus.m_last, 0);
    chk({tag, " m_data"},    bus.m_data, 0);
    chk({tag, " frame_ok"},  bus.frame_ok, 0);
    chk({tag, " frame_err"}, bus.frame_err, 0);
    chk({tag, " err_code"},  bus.err_code, 0);
  endtask

  initial begin
    logic [159:0] b16, p16;
    int ok0, err0, hs0, rd0, un0;

    set_vec(0, 6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}), 3, 160'({8'h11, 8'h22, 8'h33}), 1, 0, 2'b00);
    set_vec(1, 5, 160'({8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00}),        0, 160'(0),                      0, 1, 2'b01);
    set_vec(2, 4, 160'({8'hA5, 8'h01, 8'h5A, 8'h5B}),               1, 160'(8'h5A),                  1, 0, 2'b00);
    set_vec(3, 4, 160'({8'hA5, 8'h00, 8'h00, 8'hFF}),               0, 160'(0),                      0, 1, 2'b10);
    set_vec(4, 4, 160'({8'hA5, 8'h11, 8'h00, 8'hFF}),               0, 160'(0),                      0, 1, 2'b10);
    set_vec(5, 5, 160'({8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02}),        2, 160'({8'hA5, 8'hA5}),         1, 0, 2'b00);
    b16 = 160'({8'hA5, 8'h10});
    p16 = '0;
    for (int k = 0; k < 16; k++) begin
      b16 = (b16 << 8) | 160'(k);
      p16 = (p16 << 8) | 160'(k);
    end
    b16 = (b16 << 8) | 160'(8'h10);
    set_vec(6, 19, b16, 16, p16, 1, 0, 2'b00);
    set_vec(7, 4, 160'({8'hA5, 8'h01, 8'hFF, 8'hFE}),               1, 160'(8'hFF),                  1, 0, 2'b00);
    set_vec(8, 4, 160'({8'hA5, 8'h01, 8'h42, 8'h43}),               1, 160'(8'h42),                  1, 0, 2'b00);

    bus.m_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    step(3);
    rst_n = 1'b1;
    step(2);

    for (int v = 0; v < 8; v++) run_vec(v);

    // Backpressure with a second frame queued behind the first.
    ok0 = n_ok; err0 = n_err; hs0 = hs_data.size(); rd0 = n_rd_out; un0 = n_unstable;
    bus.m_ready = 1'b0;
    push_vec_bytes(0);
    fifo.push_back(8'hA5); fifo.push_back(8'h01); fifo.push_back(8'h77); fifo.push_back(8'h76);
    wait_ok(ok0, "bp");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp stall%0d m_valid", k), bus.m_valid, 1);
      chk($sformatf("bp stall%0d m_data", k), bus.m_data, 8'h11);
      chk($sformatf("bp stall%0d m_last", k), bus.m_last, 0);
      chk($sformatf("bp stall%0d rx_rd_en", k), bus.rx_rd_en, 0);
      step(1);
    end
    chk("bp queued bytes held", fifo.size(), 4);
    for (int t = 0; t < 80 && (hs_data.size() - hs0) < 4; t++) begin
      bus.m_ready = ~bus.m_ready;
      step(1);
    end
    bus.m_ready = 1'b1;
    step(5);
    chk("bp handshakes", hs_data.size() - hs0, 4);
    if (hs_data.size() - hs0 >= 4) begin
      chk("bp d0", hs_data[hs0],   8'h11); chk("bp l0", hs_last[hs0],   0);
      chk("bp d1", hs_data[hs0+1], 8'h22); chk("bp l1", hs_last[hs0+1], 0);
      chk("bp d2", hs_data[hs0+2], 8'h33); chk("bp l2", hs_last[hs0+2], 1);
      chk("bp d3", hs_data[hs0+3], 8'h77); chk("bp l3", hs_last[hs0+3], 1);
    end
    chk("bp frame_ok count", n_ok - ok0, 2);
    chk("bp frame_err count", n_err - err0, 0);
    chk("bp stall stability", n_unstable - un0, 0);
    chk("bp rx_rd_en in OUT", n_rd_out - rd0, 0);

    // Inter-byte timeout in PAYLOAD.
    ok0 = n_ok; err0 = n_err;
    fifo.push_back(8'hA5); fifo.push_back(8'h04); fifo.push_back(8'h01); fifo.push_back(8'h02);
    for (int t = 0; t < 300 && n_err == err0; t++) step(1);
    chk("tmo frame_err count", n_err - err0, 1);
    chk("tmo err_code", err_seen, 2'b11);
    chk("tmo latency", err_cyc - pop_cyc, TMO);
    chk("tmo no frame_ok", n_ok - ok0, 0);
    run_vec(2);

    // Reset in PAYLOAD, with a byte waiting in the FIFO during reset.
    ok0 = n_ok; err0 = n_err; hs0 = hs_data.size();
    fifo.push_back(8'hA5); fifo.push_back(8'h04); fifo.push_back(8'h01); fifo.push_back(8'h02);
    step(8);
    rst_n = 1'b0;
    #1 check_reset_outputs("rst payload");
    fifo.push_back(8'h00);
    step(3);
    chk("rst rx_rd_en gated", bus.rx_rd_en, 0);
    chk("rst byte not popped", fifo.size(), 1);
    rst_n = 1'b1;
    step(4);

    // Reset while stalled in OUT.
    bus.m_ready = 1'b0;
    push_vec_bytes(0);
    wait_ok(ok0, "rst out");
    step(2);
    chk("rst out m_valid before", bus.m_valid, 1);
    rst_n = 1'b0;
    #1 check_reset_outputs("rst out");
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("rst no frame_err", n_err - err0, 0);
    chk("rst no handshakes", hs_data.size() - hs0, 0);
    run_vec(8);

    chk("ok/err never together", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
